issue_stage: RTL

- Consumer end of the frontend decode queue: pops queue_item_t entries, checks a register scoreboard, expands packed_imm to 32 bits, and presents a registered issue packet to execute/memory over valid/ready.
- Sits between the instruction queue and register read/execute in the in-order backend.
- Owns the busy-register scoreboard; writeback clears it, flush kills the held packet.

---
 rtl/issue_stage_pkg.sv | 64 ++++++
 rtl/issue_stage_imm.sv | 27 ++
 rtl/issue_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/issue_stage_pkg.sv
// Shared control types for the frontend queue and issue stage, including the
// packed_imm layout that the decoder and imm_expand must agree on.
package issue_stage_pkg;

    localparam int REG_W      = 5;
    localparam int PIMM_W     = 20;
    localparam int PIMM_S12_W = 12;
    localparam int PIMM_S20_W = 20;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_t;

    typedef enum logic [5:0] {
        UOP_NOP = 6'd0,
        UOP_ADD = 6'd1,
        UOP_LD  = 6'd2,
        UOP_ST  = 6'd3,
        UOP_BR  = 6'd4,
        UOP_JAL = 6'd5,
        UOP_LUI = 6'd6
    } uopc_t;

    typedef enum logic [2:0] {
        EXU_ALU = 3'd0,
        EXU_LSU = 3'd1,
        EXU_BRU = 3'd2,
        EXU_MUL = 3'd3
    } exut_t;

    typedef struct packed {
        uopc_t              uopc;
        exut_t              exut;
        imm_type_t          imm_type;
        logic               has_rs1;
        logic               has_rs2;
        logic               has_rd;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic [PIMM_W-1:0]  packed_imm;
    } queue_item_t;

    // I/S keep imm[11:0], B keeps imm[12:1], U keeps imm[31:12], J keeps imm[20:1];
    // imm_expand restores the dropped low zero bit and the sign.
    function automatic logic [PIMM_W-1:0] pack_imm(input imm_type_t t, input logic [31:0] imm);
        logic [PIMM_W-1:0] p;
        p = '0;
        case (t)
            IMM_I, IMM_S: p[PIMM_S12_W-1:0] = imm[11:0];
            IMM_B:        p[PIMM_S12_W-1:0] = imm[12:1];
            IMM_U:        p[PIMM_S20_W-1:0] = imm[31:12];
            IMM_J:        p[PIMM_S20_W-1:0] = imm[20:1];
            default:      p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/issue_stage_imm.sv
// Combinational expansion of a queue item's packed_imm into a full-width immediate.
module imm_expand
    import issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [PIMM_W-1:0] i_packed_imm,
    input  imm_type_t         i_imm_type,
    output logic [XLEN-1:0]   o_imm
);

    logic [PIMM_W-1:0] w_p;

    assign w_p = i_packed_imm;

    always_comb begin
        o_imm = '0;
        case (i_imm_type)
            IMM_I, IMM_S: o_imm = {{(XLEN-12){w_p[11]}}, w_p[11:0]};
            IMM_B:        o_imm = {{(XLEN-13){w_p[11]}}, w_p[11:0], 1'b0};
            IMM_U:        o_imm = {{(XLEN-31){w_p[19]}}, w_p[18:0], 12'b0};
            IMM_J:        o_imm = {{(XLEN-21){w_p[19]}}, w_p[19:0], 1'b0};
            default:      o_imm = '0;
        endcase
    end

endmodule

// File: rtl/issue_stage.sv
// Pops decoded items from the frontend queue, blocks on the busy-register
// scoreboard and holds one registered issue packet for execute.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_q_valid,
    input  queue_item_t         i_q_item,
    input  logic [XLEN-1:0]     i_q_pc,
    output logic                o_q_ready,
    input  logic                i_flush,
    input  logic                i_wb_valid,
    input  logic [REG_W-1:0]    i_wb_rd,
    output logic                o_iss_valid,
    input  logic                i_iss_ready,
    output queue_item_t         o_iss_item,
    output logic [XLEN-1:0]     o_iss_imm,
    output logic [XLEN-1:0]     o_iss_pc,
    output logic [NREG-1:0]     o_busy_vec,
    output logic [31:0]         o_stall_cnt
);

    queue_item_t       r_item;
    logic              r_valid;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_pc;
    logic [NREG-1:0]   r_busy;
    logic [31:0]       r_stall;

    logic              w_fire_out;
    logic              w_fire_in;
    logic              w_set_rd;
    logic              w_hazard;
    logic              w_ready;
    logic              w_stall;
    logic [NREG-1:0]   w_eff;
    logic [XLEN-1:0]   w_imm;

    imm_expand #(.XLEN(XLEN)) u_imm_expand (
        .i_packed_imm (i_q_item.packed_imm),
        .i_imm_type   (i_q_item.imm_type),
        .o_imm        (w_imm)
    );

    assign w_fire_out = r_valid && i_iss_ready;
    assign w_set_rd   = w_fire_out && r_item.has_rd && (r_item.rd != '0);

    // A destination leaving this cycle is already busy for the head; a writeback
    // to that same register is older and must not clear the new reservation.
    always_comb begin
        w_eff = r_busy;
        if (w_set_rd) begin
            w_eff[r_item.rd] = 1'b1;
        end
        if (i_wb_valid && !(w_set_rd && (i_wb_rd == r_item.rd))) begin
            w_eff[i_wb_rd] = 1'b0;
        end
        w_eff[0] = 1'b0;
    end

    assign w_hazard = (i_q_item.has_rs1 && w_eff[i_q_item.rs1])
                   || (i_q_item.has_rs2 && w_eff[i_q_item.rs2])
                   || (i_q_item.has_rd && (i_q_item.rd != '0) && w_eff[i_q_item.rd]);

    assign w_ready   = !i_flush && !w_hazard && (!r_valid || i_iss_ready);
    assign w_fire_in = i_q_valid && w_ready;
    assign w_stall   = i_q_valid && !w_ready && !i_flush;
    assign o_q_ready = rst_n && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_item  <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_busy  <= '0;
            r_stall <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_fire_in) begin
                r_valid <= 1'b1;
                r_item  <= i_q_item;
                r_pc    <= i_q_pc;
                r_imm   <= w_imm;
            end else if (w_fire_out) begin
                r_valid <= 1'b0;
            end
            r_busy <= w_eff;
            if (w_stall && (r_stall != 32'hFFFF_FFFF)) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign o_iss_valid = r_valid;
    assign o_iss_item  = r_item;
    assign o_iss_imm   = r_imm;
    assign o_iss_pc    = r_pc;
    assign o_busy_vec  = r_busy;
    assign o_stall_cnt = r_stall;

endmodule
